// File: rtl/task_scheduler_param_if.sv
`default_nettype none
// ============================================================================
// Module   : task_scheduler_param_if
// Purpose  : Bundles the signals between the task scheduler, its task memory,
//            the cores it serves and the display-sync logic.
// Modports : master - scheduler side (drives fetch, load, start, status)
//            slave  - environment side (task memory, cores, display sync)
// Signals  : run, tm_rd_en, tm_addr, tm_rdata, ready, start, insn_vect,
//            insn_data, insn_load_cnt, frame_done, frame_ack, err, busy
// Revision : 1.0 - initial release
// ============================================================================
interface task_scheduler_param_if #(
    parameter int NUM_CORES = 4,
    parameter int TM_AW     = 4,
    parameter int INSN_W    = 16,
    parameter int FRAME_W   = 64,
    parameter int LC_W      = 2
);
    logic                 run;
    logic                 tm_rd_en;
    logic [TM_AW-1:0]     tm_addr;
    logic [FRAME_W-1:0]   tm_rdata;
    logic [NUM_CORES-1:0] ready;
    logic [NUM_CORES-1:0] start;
    logic [NUM_CORES-1:0] insn_vect;
    logic [INSN_W-1:0]    insn_data;
    logic [LC_W-1:0]      insn_load_cnt;
    logic                 frame_done;
    logic                 frame_ack;
    logic                 err;
    logic                 busy;

    modport master (
        input  run, tm_rdata, ready, frame_ack,
        output tm_rd_en, tm_addr, start, insn_vect, insn_data, insn_load_cnt,
               frame_done, err, busy
    );

    modport slave (
        output run, tm_rdata, ready, frame_ack,
        input  tm_rd_en, tm_addr, start, insn_vect, insn_data, insn_load_cnt,
               frame_done, err, busy
    );
endinterface
`default_nettype wire

// File: rtl/task_scheduler_param.sv
`default_nettype none
// ============================================================================
// Module   : task_scheduler_param
// Purpose  : Walks a circular task memory of control frames. A CTRL frame
//            names a core mask, a fence and a count of instruction frames
//            that follow it; each instruction frame is streamed to the masked
//            cores over LOAD_BEATS beats and then launched with a one-cycle
//            start pulse. A STOP frame drains all cores, raises frame_done
//            until acknowledged, then jumps to the frame's stop address.
// Ports    : clk   - rising-edge clock
//            reset - asynchronous, active-low reset
//            bus   - task_scheduler_param_if.master (memory, cores, sync)
// Revision : 1.0 - initial release
// ============================================================================
module task_scheduler_param #(
    parameter int NUM_CORES  = 4,
    parameter int TM_DEPTH   = 16,
    parameter int INSN_W     = 16,
    parameter int LOAD_BEATS = 4
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    task_scheduler_param_if.master      bus
);
    localparam int c_TM_AW   = $clog2(TM_DEPTH);
    localparam int c_FRAME_W = INSN_W * LOAD_BEATS;
    localparam int c_LC_W    = (LOAD_BEATS > 1) ? $clog2(LOAD_BEATS) : 1;

    localparam logic [1:0] c_KIND_CTRL = 2'b00;
    localparam logic [1:0] c_KIND_STOP = 2'b10;
    localparam logic [1:0] c_FENCE_ACQ = 2'b01;
    localparam logic [1:0] c_FENCE_REL = 2'b10;
    localparam logic [1:0] c_FENCE_BAD = 2'b11;

    localparam logic [c_TM_AW-1:0] c_PTR_ONE   = 1;
    localparam logic [c_LC_W-1:0]  c_BEAT_ONE  = 1;
    localparam logic [c_LC_W-1:0]  c_LAST_BEAT = c_LC_W'(LOAD_BEATS - 1);
    localparam logic [7:0]         c_CNT_ONE   = 8'd1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_WAIT   = 3'd3,
        S_LOAD   = 3'd4,
        S_START  = 3'd5,
        S_DRAIN  = 3'd6,
        S_SYNC   = 3'd7
    } state_t;

    state_t                 r_state;
    logic [c_TM_AW-1:0]     r_ptr;
    logic [c_TM_AW-1:0]     r_addr;
    logic                   r_rd_en;
    logic                   r_insn_phase;   // pending fetch is an insn frame
    logic [NUM_CORES-1:0]   r_mask;
    logic [1:0]             r_fence;
    logic [7:0]             r_count;        // insn frames still to launch
    logic [c_TM_AW-1:0]     r_stop_addr;
    logic                   r_drain_all;    // drain waits on every core (STOP)
    logic [c_FRAME_W-1:0]   r_frame;
    logic [c_LC_W-1:0]      r_beat;
    logic [INSN_W-1:0]      r_data;
    logic [NUM_CORES-1:0]   r_vect;
    logic [NUM_CORES-1:0]   r_start;
    logic                   r_frame_done;
    logic                   r_err;

    // Control-frame fields, decoded straight off the memory read data.
    logic [1:0]             w_kind;
    logic [1:0]             w_fence;
    logic [NUM_CORES-1:0]   w_mask;
    logic [7:0]             w_n_insn;
    logic [c_TM_AW-1:0]     w_stop;
    logic                   w_bad;

    assign w_kind   = bus.tm_rdata[1:0];
    assign w_fence  = bus.tm_rdata[3:2];
    assign w_mask   = bus.tm_rdata[4 +: NUM_CORES];
    assign w_n_insn = bus.tm_rdata[4 + NUM_CORES +: 8];
    assign w_stop   = bus.tm_rdata[12 + NUM_CORES +: c_TM_AW];
    assign w_bad    = ((w_kind != c_KIND_CTRL) && (w_kind != c_KIND_STOP)) ||
                      (w_fence == c_FENCE_BAD);

    logic w_all_ready;
    logic w_mask_ready;
    logic w_wait_ok;
    logic w_drain_ok;

    assign w_all_ready  = &bus.ready;
    assign w_mask_ready = ((r_mask & ~bus.ready) == '0);
    assign w_wait_ok    = (r_fence == c_FENCE_ACQ) ? w_all_ready : w_mask_ready;
    assign w_drain_ok   = r_drain_all ? w_all_ready : w_mask_ready;

    // Latched insn frame split into beats; beat k is bits [k*INSN_W +: INSN_W].
    logic [INSN_W-1:0] w_beats [LOAD_BEATS];
    logic [c_LC_W-1:0] w_next_beat;

    for (genvar g = 0; g < LOAD_BEATS; g++) begin : g_beat
        assign w_beats[g] = r_frame[g*INSN_W +: INSN_W];
    end

    assign w_next_beat = r_beat + c_BEAT_ONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_addr       <= '0;
            r_rd_en      <= 1'b0;
            r_insn_phase <= 1'b0;
            r_mask       <= '0;
            r_fence      <= '0;
            r_count      <= '0;
            r_stop_addr  <= '0;
            r_drain_all  <= 1'b0;
            r_frame      <= '0;
            r_beat       <= '0;
            r_data       <= '0;
            r_vect       <= '0;
            r_start      <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.run) begin
                        r_rd_en      <= 1'b1;
                        r_addr       <= r_ptr;
                        r_insn_phase <= 1'b0;
                        r_state      <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    r_rd_en <= 1'b0;
                    r_state <= S_DECODE;
                end

                S_DECODE: begin
                    if (r_insn_phase) begin
                        // Beat 0 is presented on the first LOAD cycle.
                        r_frame <= bus.tm_rdata;
                        r_data  <= bus.tm_rdata[INSN_W-1:0];
                        r_vect  <= r_mask;
                        r_beat  <= '0;
                        r_state <= S_LOAD;
                    end else if (w_bad) begin
                        r_err   <= 1'b1;
                        r_ptr   <= r_ptr + c_PTR_ONE;
                        r_state <= S_IDLE;
                    end else if (w_kind == c_KIND_STOP) begin
                        // The pointer is replaced by the stop address on ack.
                        r_stop_addr <= w_stop;
                        r_drain_all <= 1'b1;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_mask      <= w_mask;
                        r_fence     <= w_fence;
                        r_count     <= w_n_insn;
                        r_drain_all <= 1'b0;
                        r_ptr       <= r_ptr + c_PTR_ONE;
                        if (w_n_insn != 8'd0) begin
                            r_state <= S_WAIT;
                        end else if (w_fence == c_FENCE_REL) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                S_WAIT: begin
                    if (w_wait_ok) begin
                        r_rd_en      <= 1'b1;
                        r_addr       <= r_ptr;
                        r_insn_phase <= 1'b1;
                        r_state      <= S_FETCH;
                    end
                end

                S_LOAD: begin
                    if (r_beat == c_LAST_BEAT) begin
                        r_beat  <= '0;
                        r_data  <= '0;
                        r_vect  <= '0;
                        r_start <= r_mask;
                        r_state <= S_START;
                    end else begin
                        r_beat <= w_next_beat;
                        r_data <= w_beats[w_next_beat];
                    end
                end

                S_START: begin
                    // Ready is not looked at here: a core that was just
                    // started may not have dropped ready yet.
                    r_start <= '0;
                    r_count <= r_count - c_CNT_ONE;
                    r_ptr   <= r_ptr + c_PTR_ONE;
                    if (r_count != c_CNT_ONE) begin
                        r_state <= S_WAIT;
                    end else if (r_fence == c_FENCE_REL) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_DRAIN: begin
                    if (w_drain_ok) begin
                        if (r_drain_all) begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_SYNC;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                S_SYNC: begin
                    if (bus.frame_ack) begin
                        r_frame_done <= 1'b0;
                        r_drain_all  <= 1'b0;
                        r_ptr        <= r_stop_addr;
                        r_state      <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.tm_rd_en      = r_rd_en;
    assign bus.tm_addr       = r_addr;
    assign bus.start         = r_start;
    assign bus.insn_vect     = r_vect;
    assign bus.insn_data     = r_data;
    assign bus.insn_load_cnt = r_beat;
    assign bus.frame_done    = r_frame_done;
    assign bus.err           = r_err;
    assign bus.busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_task_scheduler_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_task_scheduler_param
// Purpose  : Directed bench for task_scheduler_param (4 cores, 16 frames,
//            16-bit insns, 4 beats). A task-memory image exercises plain,
//            acquire and release groups, error frames, an empty-mask group,
//            STOP/sync with jump, pointer wrap and reset during LOAD.
// Revision : 1.0 - initial release
// ============================================================================
module tb_task_scheduler_param;
    localparam int c_NC = 4;
    localparam int c_AW = 4;
    localparam int c_IW = 16;
    localparam int c_FW = 64;
    localparam int c_LW = 2;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_miss;

    logic [c_FW-1:0] mem [16];

    task_scheduler_param_if #(
        .NUM_CORES (c_NC),
        .TM_AW     (c_AW),
        .INSN_W    (c_IW),
        .FRAME_W   (c_FW),
        .LC_W      (c_LW)
    ) bus ();

    task_scheduler_param #(
        .NUM_CORES  (c_NC),
        .TM_DEPTH   (16),
        .INSN_W     (c_IW),
        .LOAD_BEATS (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read task memory: data appears the cycle after tm_rd_en.
    always @(posedge clk) begin
        if (bus.tm_rd_en) bus.tm_rdata <= mem[bus.tm_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Step at least one cycle, then until a fetch is seen (bounded).
    task automatic wait_fetch(input string tag, input int exp_lat, input logic [3:0] exp_addr);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.tm_rd_en && n < 40);
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_addr"}, 64'(bus.tm_addr), 64'(exp_addr));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rd_en"}, 64'(bus.tm_rd_en), 0);
        chk({tag, "_addr"},  64'(bus.tm_addr), 0);
        chk({tag, "_start"}, 64'(bus.start), 0);
        chk({tag, "_vect"},  64'(bus.insn_vect), 0);
        chk({tag, "_data"},  64'(bus.insn_data), 0);
        chk({tag, "_cnt"},   64'(bus.insn_load_cnt), 0);
        chk({tag, "_fdone"}, 64'(bus.frame_done), 0);
        chk({tag, "_err"},   64'(bus.err), 0);
        chk({tag, "_busy"},  64'(bus.busy), 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0]  = 64'h250;                  // CTRL NO  mask 0101 n=2
        mem[1]  = 64'h1111_2222_3333_4444;
        mem[2]  = 64'hAAAA_BBBB_CCCC_DDDD;
        mem[3]  = 64'h114;                  // CTRL ACQ mask 0001 n=1
        mem[4]  = 64'h0123_4567_89AB_CDEF;
        mem[5]  = 64'h138;                  // CTRL REL mask 0011 n=1
        mem[6]  = 64'hFEED_FACE_CAFE_BEEF;
        mem[7]  = 64'h3;                    // kind 11 -> error
        mem[8]  = 64'hC;                    // fence 11 -> error
        mem[9]  = 64'h100;                  // CTRL NO  mask 0000 n=1
        mem[10] = 64'h5555_6666_7777_8888;
        mem[11] = 64'h28;                   // CTRL REL mask 0010 n=0
        mem[12] = 64'h0;                    // CTRL NO  n=0
        mem[13] = 64'h0;
        mem[14] = 64'h0;
        mem[15] = 64'h5_0002;               // STOP -> 5

        reset          = 1'b0;
        bus.run        = 1'b0;
        bus.ready      = 4'hF;
        bus.frame_ack  = 1'b0;
        bus.tm_rdata   = '0;

        // Reset state
        tick(2);
        chk_zero("rst");
        reset = 1'b1;
        tick(1);
        chk("idle_norun_busy", 64'(bus.busy), 0);
        chk("idle_norun_rd", 64'(bus.tm_rd_en), 0);
        bus.run = 1'b1;

        // Group at 0: two insns, mask 0101, no fence
        wait_fetch("t1_f0", 1, 4'd0);
        chk("t1_busy", 64'(bus.busy), 1);
        wait_fetch("t1_f1", 3, 4'd1);
        tick(2);
        chk("t1_b0_vect", 64'(bus.insn_vect), 64'h5);
        chk("t1_b0_data", 64'(bus.insn_data), 64'h4444);
        chk("t1_b0_cnt",  64'(bus.insn_load_cnt), 0);
        tick(1);
        chk("t1_b1_data", 64'(bus.insn_data), 64'h3333);
        chk("t1_b1_cnt",  64'(bus.insn_load_cnt), 1);
        tick(1);
        chk("t1_b2_data", 64'(bus.insn_data), 64'h2222);
        tick(1);
        chk("t1_b3_data", 64'(bus.insn_data), 64'h1111);
        chk("t1_b3_cnt",  64'(bus.insn_load_cnt), 3);
        chk("t1_b3_start", 64'(bus.start), 0);
        tick(1);
        chk("t1_start", 64'(bus.start), 64'h5);
        chk("t1_start_vect", 64'(bus.insn_vect), 0);
        chk("t1_start_cnt", 64'(bus.insn_load_cnt), 0);
        tick(1);
        chk("t1_start_once", 64'(bus.start), 0);
        wait_fetch("t1_f2", 1, 4'd2);
        tick(2);
        chk("t1_i2_b0", 64'(bus.insn_data), 64'hDDDD);
        tick(3);
        chk("t1_i2_b3", 64'(bus.insn_data), 64'hAAAA);
        tick(1);
        chk("t1_start2", 64'(bus.start), 64'h5);
        tick(1);
        chk("t1_idle_busy", 64'(bus.busy), 0);
        bus.ready = 4'b1110;
        wait_fetch("t1_f3", 1, 4'd3);

        // Group at 3: acquire fence waits for every core
        tick(2);
        chk("t2_wait_rd", 64'(bus.tm_rd_en), 0);
        chk("t2_wait_busy", 64'(bus.busy), 1);
        tick(1);
        bus.ready = 4'b0111;                // masked core ready, core 3 not
        tick(1);
        chk("t2_acq_hold", 64'(bus.tm_rd_en), 0);
        tick(1);
        chk("t2_acq_hold2", 64'(bus.tm_rd_en), 0);
        bus.ready = 4'hF;
        wait_fetch("t2_f4", 1, 4'd4);
        tick(2);
        chk("t2_b0_vect", 64'(bus.insn_vect), 64'h1);
        chk("t2_b0_data", 64'(bus.insn_data), 64'hCDEF);
        tick(3);
        chk("t2_b3_data", 64'(bus.insn_data), 64'h0123);
        tick(1);
        chk("t2_start", 64'(bus.start), 64'h1);
        tick(1);
        chk("t2_idle", 64'(bus.busy), 0);
        wait_fetch("t2_f5", 1, 4'd5);

        // Group at 5: release fence drains masked cores
        wait_fetch("t3_f6", 3, 4'd6);
        tick(2);
        chk("t3_b0_vect", 64'(bus.insn_vect), 64'h3);
        chk("t3_b0_data", 64'(bus.insn_data), 64'hBEEF);
        tick(3);
        chk("t3_b3_data", 64'(bus.insn_data), 64'hFEED);
        tick(1);
        chk("t3_start", 64'(bus.start), 64'h3);
        bus.ready = 4'b1110;                // core 0 busy for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("t3_drain_rd", 64'(bus.tm_rd_en), 0);
            chk("t3_drain_busy", 64'(bus.busy), 1);
        end
        bus.ready = 4'hF;
        tick(1);
        chk("t3_idle", 64'(bus.busy), 0);
        wait_fetch("t3_f7", 1, 4'd7);

        // Error frames at 7 and 8
        tick(2);
        chk("t4_err", 64'(bus.err), 1);
        chk("t4_idle", 64'(bus.busy), 0);
        wait_fetch("t4_f8", 1, 4'd8);
        tick(2);
        chk("t4_err_sticky", 64'(bus.err), 1);
        wait_fetch("t4_f9", 1, 4'd9);

        // Group at 9: empty mask, run dropped mid-group
        tick(2);
        bus.run = 1'b0;
        wait_fetch("t5_f10", 1, 4'd10);
        tick(2);
        chk("t5_b0_vect", 64'(bus.insn_vect), 0);
        chk("t5_b0_data", 64'(bus.insn_data), 64'h8888);
        tick(1);
        chk("t5_b1_data", 64'(bus.insn_data), 64'h7777);
        chk("t5_b1_cnt",  64'(bus.insn_load_cnt), 1);
        tick(2);
        chk("t5_b3_data", 64'(bus.insn_data), 64'h5555);
        tick(1);
        chk("t5_start_busy", 64'(bus.busy), 1);
        chk("t5_start_zero", 64'(bus.start), 0);
        tick(1);
        chk("t5_idle", 64'(bus.busy), 0);
        tick(3);
        chk("t5_hold_rd", 64'(bus.tm_rd_en), 0);
        chk("t5_hold_busy", 64'(bus.busy), 0);
        bus.run = 1'b1;
        wait_fetch("t5_f11", 1, 4'd11);

        // Frame 11: release with n=0 drains masked core 1
        bus.ready = 4'b1101;
        tick(2);
        chk("t6_drain", 64'(bus.busy), 1);
        tick(1);
        chk("t6_drain2", 64'(bus.busy), 1);
        bus.ready = 4'hF;
        tick(1);
        chk("t6_idle", 64'(bus.busy), 0);
        wait_fetch("t6_f12", 1, 4'd12);
        wait_fetch("t6_f13", 3, 4'd13);
        wait_fetch("t6_f14", 3, 4'd14);
        wait_fetch("t6_f15", 3, 4'd15);

        // STOP at 15 -> sync, then jump to 5
        tick(1);
        bus.frame_ack = 1'b1;               // outside SYNC: ignored
        tick(1);
        bus.frame_ack = 1'b0;
        chk("t7_early_ack_fd", 64'(bus.frame_done), 0);
        tick(1);
        chk("t7_fdone", 64'(bus.frame_done), 1);
        tick(2);
        chk("t7_fdone_hold", 64'(bus.frame_done), 1);
        chk("t7_busy", 64'(bus.busy), 1);
        bus.frame_ack = 1'b1;
        tick(1);
        chk("t7_fdone_clr", 64'(bus.frame_done), 0);
        chk("t7_idle", 64'(bus.busy), 0);
        bus.frame_ack = 1'b0;
        bus.run = 1'b0;
        mem[5]  = 64'hF_0002;               // STOP -> 15
        mem[15] = 64'h140;                  // CTRL NO mask 0100 n=1
        mem[0]  = 64'h0F0F_F0F0_1234_5678;
        tick(2);
        chk("t7_run_low", 64'(bus.tm_rd_en), 0);
        bus.run = 1'b1;
        wait_fetch("t7_f5", 1, 4'd5);
        tick(3);
        chk("t7b_fdone", 64'(bus.frame_done), 1);
        bus.frame_ack = 1'b1;               // ack on first SYNC cycle
        tick(1);
        chk("t7b_fdone_clr", 64'(bus.frame_done), 0);
        bus.frame_ack = 1'b0;
        wait_fetch("t7b_f15", 1, 4'd15);

        // CTRL at 15: insn fetched from 0 (wrap), reset during LOAD
        wait_fetch("t8_wrap", 3, 4'd0);
        tick(2);
        chk("t8_b0_vect", 64'(bus.insn_vect), 64'h4);
        chk("t8_b0_data", 64'(bus.insn_data), 64'h5678);
        tick(1);
        chk("t8_b1_data", 64'(bus.insn_data), 64'h1234);
        chk("t8_err_kept", 64'(bus.err), 1);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("t9_async");
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("t9_no_start", 64'(bus.start), 0);
        end
        mem[0] = 64'h0;
        reset = 1'b1;
        wait_fetch("t9_restart", 1, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/task_scheduler_param.md
TASK_SCHEDULER_PARAM -- requirements
Module: task_scheduler_param

Interface
REQ-001 SHALL have parameter NUM_CORES, 4, number of cores served (1..32).
REQ-002 SHALL have parameter TM_DEPTH, 16, task-memory depth in frames (power of two, >=4); TM_AW = log2(TM_DEPTH).
REQ-003 SHALL have parameter INSN_W, 16, instruction width; LOAD_BEATS, 4, instructions per insn frame; FRAME_W = INSN_W*LOAD_BEATS, with FRAME_W >= 4+NUM_CORES+8+TM_AW.
REQ-004 SHALL have clk in 1, rising-edge clock.
REQ-005 SHALL have reset in 1; reset is asynchronous and active-low.
REQ-006 SHALL have run in 1, level enable; when low, no new frame fetch starts.
REQ-007 SHALL have tm_rd_en out 1, tm_addr out TM_AW, tm_rdata in FRAME_W; synchronous read, data valid the cycle after tm_rd_en.
REQ-008 SHALL have ready in NUM_CORES (core idle), start out NUM_CORES, insn_vect out NUM_CORES, insn_data out INSN_W, insn_load_cnt out log2(LOAD_BEATS) (min 1).
REQ-009 SHALL have frame_done out 1 (display-sync request), frame_ack in 1, err out 1 (sticky), busy out 1.

Function
REQ-010 Control-frame fields SHALL be: [1:0] kind (00 CTRL, 10 STOP, other = error); [3:2] fence (00 NO, 01 ACQ, 10 REL, 11 = error); [4+:NUM_CORES] core mask; next 8 bits n_insn; next TM_AW bits stop address.
REQ-011 A CTRL frame SHALL be followed by n_insn raw insn frames at consecutive addresses; pointer increments modulo TM_DEPTH (TM_DEPTH-1 wraps to 0).
REQ-012 FSM states SHALL be IDLE, FETCH, DECODE, WAIT, LOAD, START, DRAIN, SYNC; reset state IDLE.
REQ-013 IDLE -> FETCH when run=1; FETCH drives tm_rd_en=1, tm_addr=ptr for exactly one cycle; DECODE captures tm_rdata the next cycle.
REQ-014 DECODE of CTRL: latch mask, fence, n_insn; ptr+1; fence ACQ -> WAIT with all-cores condition; otherwise WAIT with masked condition; n_insn=0 with fence REL -> DRAIN, with fence NO/ACQ -> IDLE.
REQ-015 WAIT condition: masked = (mask & ~ready)==0; all-cores = ready all ones; on condition, FETCH of next insn frame then LOAD.
REQ-016 LOAD SHALL last exactly LOAD_BEATS cycles; beat k drives insn_data = frame[k*INSN_W +: INSN_W], insn_load_cnt = k, insn_vect = mask; outside LOAD insn_vect = 0, insn_load_cnt = 0.
REQ-017 START SHALL drive start = mask for exactly one cycle, decrement remaining count, ptr+1; WAIT is then re-entered no earlier than the following cycle, so ready sampled in the START cycle is ignored.
REQ-018 After the last insn frame: fence REL -> DRAIN, else IDLE; DRAIN exits to IDLE when (mask & ~ready)==0.
REQ-019 DECODE of STOP: go to DRAIN-all (ready all ones), then SYNC: frame_done=1 held until frame_ack=1; on ack ptr <= stop address, -> IDLE.
REQ-020 frame_ack while not in SYNC SHALL be ignored; ack in the first SYNC cycle completes SYNC in that cycle.
REQ-021 Error kind or fence SHALL set err=1 (cleared only by reset), ptr+1, frame skipped -> IDLE.
REQ-022 run deasserted mid-group SHALL not abort; group completes, then IDLE holds.
REQ-023 mask = 0 SHALL still step through LOAD/START with start = 0 (frames consumed, timing unchanged).
REQ-024 busy = 1 in every state except IDLE.

Reset
REQ-025 Asserting reset SHALL asynchronously force state IDLE, ptr=0, start=0, insn_vect=0, insn_data=0, insn_load_cnt=0, tm_rd_en=0, tm_addr=0, frame_done=0, err=0, busy=0, mask/fence/count=0.
REQ-026 Reset mid-LOAD or mid-SYNC SHALL abort with no further start pulse; first fetch after release is from address 0.

Verification
REQ-027 NUM_CORES=4: CTRL(NO, mask 0101, n=2) at 0, insn at 1,2, all ready -> 4 beats, start=0101 one cycle, repeat, then FETCH addr 3.
REQ-028 CTRL(ACQ, mask 0001), ready=1110 -> no LOAD until ready=1111, LOAD starts 2 cycles later (FETCH, DECODE).
REQ-029 CTRL(REL, mask 0011, n=1), core0 busy 10 cycles after start -> next FETCH only after ready[1:0]=11.
REQ-030 STOP(addr 5) at 15 (TM_DEPTH=16) -> frame_done held until frame_ack, then FETCH addr 5; CTRL n=1 at 15 fetches insn at 0 (wrap).
REQ-031 kind=11 at addr 0 -> err=1 sticky, next FETCH addr 1; reset low mid-LOAD -> all outputs 0 immediately, restart from addr 0.
